anubis_stream_ctrl: RTL and testbench

- Word-serial front/back end for the Anubis_2 encryption core; sits directly in front of it and drives its data_in, order and reset.
- Assembles 32-bit input words into a 128-bit key or plaintext block and replays the stored key into the core before every block, because the core overwrites its key register during rounds.
- Sequences the core through reset, key load, plaintext load and run.
- Captures the 128-bit ciphertext and returns it as four 32-bit words over a valid/ready handshake.

---
 rtl/anubis_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_anubis_stream_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anubis_stream_ctrl.sv
// Word-serial front/back end for the Anubis core: packs 32-bit words into key/plaintext blocks,
// sequences the core through reset/key/plaintext/run and drains the ciphertext MSW-first over valid/ready.
module anubis_stream_ctrl #(
  parameter int KEY_CYC = 3,
  parameter int PT_CYC  = 2,
  parameter int RUN_CYC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_is_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         key_loaded,
  output logic         drop_err,
  output logic         core_reset,
  output logic [1:0]   core_order,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out
);

  typedef enum logic [2:0] {COLLECT, C_RST, C_KEY, C_PT, C_RUN, CAPTURE, DRAIN} state_t;
  localparam int CW = 8;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic           is_key_q, is_key_d;
  logic [127:0]   blk_q, blk_d, key_q, key_d, obuf_q, obuf_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [31:0]    out_data_q, out_data_d;
  logic           key_loaded_q, key_loaded_d, drop_err_q, drop_err_d;
  logic           core_reset_q, core_reset_d;
  logic [1:0]     core_order_q, core_order_d;
  logic [127:0]   core_data_in_q, core_data_in_d;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign key_loaded   = key_loaded_q;
  assign drop_err     = drop_err_q;
  assign core_reset   = core_reset_q;
  assign core_order   = core_order_q;
  assign core_data_in = core_data_in_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    is_key_d     = is_key_q;
    blk_d        = blk_q;
    key_d        = key_q;
    obuf_d       = obuf_q;
    key_loaded_d = key_loaded_q;
    drop_err_d   = drop_err_q;

    case (state_q)
      COLLECT: begin
        if (in_valid && in_ready_q) begin
          // word 0 lands in [127:96], word 3 in [31:0]
          blk_d[{~wcnt_q, 5'b0} +: 32] = in_data;
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd0) is_key_d = in_is_key;
          if (wcnt_q == 2'd3) begin
            if (is_key_q) begin
              key_d        = blk_d;
              key_loaded_d = 1'b1;
            end else if (key_loaded_q) begin
              state_d = C_RST;
            end else begin
              drop_err_d = 1'b1;
            end
          end
        end
      end
      C_RST: begin
        state_d = C_KEY;
        cnt_d   = CW'(KEY_CYC - 1);
      end
      C_KEY: begin
        if (cnt_q == '0) begin
          state_d = C_PT;
          cnt_d   = CW'(PT_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      C_PT: begin
        if (cnt_q == '0) begin
          state_d = C_RUN;
          cnt_d   = CW'(RUN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      C_RUN: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CAPTURE: begin
        obuf_d  = core_data_out;
        wcnt_d  = 2'd0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    in_ready_d     = (state_d == COLLECT);
    out_valid_d    = (state_d == DRAIN);
    out_data_d     = (state_d == DRAIN) ? obuf_d[{~wcnt_d, 5'b0} +: 32] : 32'd0;
    core_reset_d   = (state_d == C_RST);
    core_order_d   = 2'b11;
    core_data_in_d = core_data_in_q;
    case (state_d)
      C_KEY: begin
        core_order_d   = 2'b00;
        core_data_in_d = key_q;
      end
      C_PT: begin
        core_order_d   = 2'b01;
        core_data_in_d = blk_q;
      end
      C_RUN, CAPTURE: core_data_in_d = blk_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      wcnt_q         <= 2'd0;
      is_key_q       <= 1'b0;
      blk_q          <= '0;
      key_q          <= '0;
      obuf_q         <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 32'd0;
      key_loaded_q   <= 1'b0;
      drop_err_q     <= 1'b0;
      core_reset_q   <= 1'b1;
      core_order_q   <= 2'b11;
      core_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wcnt_q         <= wcnt_d;
      is_key_q       <= is_key_d;
      blk_q          <= blk_d;
      key_q          <= key_d;
      obuf_q         <= obuf_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      key_loaded_q   <= key_loaded_d;
      drop_err_q     <= drop_err_d;
      core_reset_q   <= core_reset_d;
      core_order_q   <= core_order_d;
      core_data_in_q <= core_data_in_d;
    end
  end

endmodule

// File: tb/tb_anubis_stream_ctrl.sv
// Directed bench for anubis_stream_ctrl with a toy key-destroying core model behind it.
module tb_anubis_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = 32'd0;
  logic         in_is_key = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         key_loaded;
  logic         drop_err;
  logic         core_reset;
  logic [1:0]   core_order;
  logic [127:0] core_data_in;
  logic [127:0] core_data_out;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] PT1 = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
  localparam logic [127:0] PT2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] PT3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  always #5 clk = ~clk;

  anubis_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_loaded(key_loaded), .drop_err(drop_err),
    .core_reset(core_reset), .core_order(core_order),
    .core_data_in(core_data_in), .core_data_out(core_data_out)
  );

  // Core model: rounds rewrite its key register, so a missing key replay corrupts the result.
  logic [127:0] ck = '0, cs = '0;
  int           rnd = 0;
  assign core_data_out = cs;

  always @(posedge clk) begin
    if (core_reset) begin
      ck <= '0; cs <= '0; rnd <= 0;
    end else begin
      case (core_order)
        2'b00: ck <= core_data_in;
        2'b01: begin cs <= core_data_in; rnd <= 0; end
        2'b11: if (rnd < 14) begin
          cs  <= {cs[126:0], cs[127]} ^ ck;
          ck  <= {ck[0], ck[127:1]} ^ 128'h5;
          rnd <= rnd + 1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] s, kk;
    s = pt; kk = k;
    for (int i = 0; i < 14; i++) begin
      s  = {s[126:0], s[127]} ^ kk;
      kk = {kk[0], kk[127:1]} ^ 128'h5;
    end
    return s;
  endfunction

  // Entered and left at a negedge.
  task automatic send_word(input logic [31:0] d, input logic k);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_is_key = k;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk); done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_word timeout: in_ready=%0b required 1", in_ready);
    end
  endtask

  // in_is_key is inverted on words 1-3 to show only word 0 matters.
  task automatic send_block(input logic [127:0] blk, input logic k);
    for (int w = 0; w < 4; w++)
      send_word(blk[(3 - w) * 32 +: 32], (w == 0) ? k : ~k);
  endtask

  task automatic wait_out();
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_out timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic drain(input logic [127:0] ct);
    for (int k = 0; k < 4; k++) begin
      wait_out();
      checks++;
      if (out_data !== ct[(3 - k) * 32 +: 32]) begin
        errors++;
        $display("FAIL drain word %0d: out_data=%h required %h", k, out_data, ct[(3 - k) * 32 +: 32]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain end: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  // Called at the negedge right after the last plaintext handshake (cycle 0 = C_RST).
  task automatic check_sequence(input logic [127:0] k, input logic [127:0] pt);
    logic [3:0]   exp_ctl;
    logic [127:0] exp_din;
    for (int i = 0; i < 23; i++) begin
      if (i == 0)      exp_ctl = {1'b1, 2'b11, 1'b0};
      else if (i <= 3) exp_ctl = {1'b0, 2'b00, 1'b0};
      else if (i <= 5) exp_ctl = {1'b0, 2'b01, 1'b0};
      else             exp_ctl = {1'b0, 2'b11, 1'b0};
      exp_din = (i <= 3) ? k : pt;
      checks++;
      if ({core_reset, core_order, out_valid} !== exp_ctl || in_ready !== 1'b0 ||
          (i > 0 && core_data_in !== exp_din)) begin
        errors++;
        $display("FAIL seq cycle %0d: rst/ord/ov=%b in_ready=%0b din=%h required %b 0 %h",
                 i, {core_reset, core_order, out_valid}, in_ready, core_data_in, exp_ctl, exp_din);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%0b at cycle 23 required 1", out_valid);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 || key_loaded !== 1'b0 ||
        drop_err !== 1'b0 || core_reset !== 1'b1 || core_order !== 2'b11 || core_data_in !== '0) begin
      errors++;
      $display("FAIL reset values: ir=%0b ov=%0b od=%h kl=%0b de=%0b cr=%0b co=%b din=%h required 0 0 0 0 0 1 11 0",
               in_ready, out_valid, out_data, key_loaded, drop_err, core_reset, core_order, core_data_in);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || core_reset !== 1'b0 || core_order !== 2'b11) begin
      errors++;
      $display("FAIL idle after reset: ir=%0b cr=%0b co=%b required 1 0 11", in_ready, core_reset, core_order);
    end
  endtask

  task automatic test_drop_no_key();
    int bad = 0;
    send_block(PT1, 1'b0);
    checks++;
    if (drop_err !== 1'b1 || in_ready !== 1'b1 || key_loaded !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_key: de=%0b ir=%0b kl=%0b required 1 1 0", drop_err, in_ready, key_loaded);
    end
    for (int i = 0; i < 30; i++) begin
      if (core_reset !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_idle: %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_key_load();
    int bad = 0;
    for (int w = 0; w < 4; w++) begin
      send_word(KEY[(3 - w) * 32 +: 32], (w == 0) ? 1'b1 : 1'b0);
      if (core_order !== 2'b11 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (key_loaded !== 1'b1 || bad != 0 || core_reset !== 1'b0 || drop_err !== 1'b1) begin
      errors++;
      $display("FAIL key_load: kl=%0b bad=%0d cr=%0b de=%0b required 1 0 0 1", key_loaded, bad, core_reset, drop_err);
    end
  endtask

  task automatic test_block_sequence();
    send_block(PT1, 1'b0);
    check_sequence(KEY, PT1);
    drain(core_fn(KEY, PT1));
  endtask

  task automatic test_back_to_back();
    send_block(PT2, 1'b0);
    check_sequence(KEY, PT2);
    drain(core_fn(KEY, PT2));
    send_block(PT3, 1'b0);
    check_sequence(KEY, PT3);
    drain(core_fn(KEY, PT3));
  endtask

  task automatic test_stall();
    logic [127:0] ct;
    ct = core_fn(KEY, PT3);
    send_block(PT3, 1'b0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_is_key = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ct[127:96] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle %0d: ov=%0b od=%h ir=%0b required 1 %h 0", i, out_valid, out_data, in_ready, ct[127:96]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain(ct);
    send_block(PT1, 1'b0);
    wait_out();
    drain(core_fn(KEY, PT1));
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    send_block(PT2, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (core_order !== 2'b11 || core_reset !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre-reset run: co=%b cr=%0b ir=%0b required 11 0 0", core_order, core_reset, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (core_reset !== 1'b1 || key_loaded !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
        drop_err !== 1'b0 || core_data_in !== '0) begin
      errors++;
      $display("FAIL mid_run reset: cr=%0b kl=%0b ov=%0b ir=%0b de=%0b din=%h required 1 0 0 0 0 0",
               core_reset, key_loaded, out_valid, in_ready, drop_err, core_data_in);
    end
    reset = 1'b0;
    @(negedge clk);
    send_block(PT1, 1'b0);
    checks++;
    if (drop_err !== 1'b1 || key_loaded !== 1'b0) begin
      errors++;
      $display("FAIL drop_after_reset: de=%0b kl=%0b required 1 0", drop_err, key_loaded);
    end
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0 || core_reset !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no output after drop: %0d bad cycles required 0", bad);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_drop_no_key();
    test_key_load();
    test_block_sequence();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
